// File: rtl/ysyx_22040759_id_ex_stage_pkg.sv
// Shared constants for the ID/EX stage: control-bus bit positions, NOP control word, register index width.
package ysyx_22040759_id_ex_stage_pkg;

  localparam int REG_ADDR_W    = 5;
  localparam int CTRL_REGWRITE = 0;
  localparam int CTRL_MEMREAD  = 3;

  // The NOP control word is all-zero, so REGWRITE and MEMREAD are both clear.
  localparam logic [15:0] CTRL_NOP = 16'h0000;

endpackage

// File: rtl/ysyx_22040759_id_ex_stage_load_use_detect.sv
// Combinational load-use detector: a load in EX whose nonzero rd is read by the decode instruction.
import ysyx_22040759_id_ex_stage_pkg::*;

module ysyx_22040759_load_use_detect (
  input  logic                  ex_valid_i,
  input  logic                  ex_memread_i,
  input  logic [REG_ADDR_W-1:0] ex_rd_i,
  input  logic [REG_ADDR_W-1:0] id_rs1_i,
  input  logic [REG_ADDR_W-1:0] id_rs2_i,
  input  logic                  id_rs1_used_i,
  input  logic                  id_rs2_used_i,
  output logic                  load_use_o
);

  logic rs1_hit;
  logic rs2_hit;

  assign rs1_hit    = id_rs1_used_i && (id_rs1_i == ex_rd_i);
  assign rs2_hit    = id_rs2_used_i && (id_rs2_i == ex_rd_i);
  // x0 is hardwired to zero, so a load targeting it never creates a dependency.
  assign load_use_o = ex_valid_i && ex_memread_i && (ex_rd_i != '0) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/ysyx_22040759_id_ex_stage.sv
// ID/EX pipeline register with handshake, load-use bubble insertion and flush.
// Optional hazard statistics counters are built when YSYX_22040759_HAZARD_STAT_EN is defined.
import ysyx_22040759_id_ex_stage_pkg::*;

module ysyx_22040759_id_ex_stage #(
  parameter int XLEN   = 64,
  parameter int CTRL_W = 16,
  parameter int CNT_W  = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  id_valid,
  output logic                  id_ready,
  input  logic [XLEN-1:0]       id_pc,
  input  logic [31:0]           id_inst,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_rs1_used,
  input  logic                  id_rs2_used,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic [XLEN-1:0]       id_rs1_data,
  input  logic [XLEN-1:0]       id_rs2_data,
  input  logic [XLEN-1:0]       id_imm,
  input  logic [CTRL_W-1:0]     id_ctrl,
  input  logic                  ex_ready,
  input  logic                  ex_flush,
  output logic                  ex_valid,
  output logic [REG_ADDR_W-1:0] ID_EX_RegisterRs1,
  output logic [REG_ADDR_W-1:0] ID_EX_RegisterRs2,
  output logic [REG_ADDR_W-1:0] ex_rd,
  output logic [XLEN-1:0]       ex_pc,
  output logic [31:0]           ex_inst,
  output logic [XLEN-1:0]       ex_rs1_data,
  output logic [XLEN-1:0]       ex_rs2_data,
  output logic [XLEN-1:0]       ex_imm,
  output logic [CTRL_W-1:0]     ex_ctrl,
  output logic [CNT_W-1:0]      stat_bubble_cnt,
  output logic [CNT_W-1:0]      stat_flush_cnt
);

  typedef struct packed {
    logic [XLEN-1:0]       pc;
    logic [31:0]           inst;
    logic [REG_ADDR_W-1:0] rs1;
    logic [REG_ADDR_W-1:0] rs2;
    logic                  rs1_used;
    logic                  rs2_used;
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       rs1_data;
    logic [XLEN-1:0]       rs2_data;
    logic [XLEN-1:0]       imm;
    logic [CTRL_W-1:0]     ctrl;
  } entry_t;

  logic   valid_q, valid_d;
  entry_t entry_q, entry_d;
  logic   load_use;
  logic   in_fire;
  logic   out_fire;

  ysyx_22040759_load_use_detect u_load_use_detect (
    .ex_valid_i    (valid_q),
    .ex_memread_i  (entry_q.ctrl[CTRL_MEMREAD]),
    .ex_rd_i       (entry_q.rd),
    .id_rs1_i      (id_rs1),
    .id_rs2_i      (id_rs2),
    .id_rs1_used_i (id_rs1_used),
    .id_rs2_used_i (id_rs2_used),
    .load_use_o    (load_use)
  );

  assign id_ready = !ex_flush && !load_use && (!valid_q || ex_ready);
  assign in_fire  = id_valid && id_ready;
  assign out_fire = valid_q && ex_ready;

  // NOTE: every variable gets a default at the top of always_comb so no path can infer a latch.
  always_comb begin
    valid_d = valid_q;
    if (ex_flush)      valid_d = 1'b0;
    else if (in_fire)  valid_d = 1'b1;
    else if (out_fire) valid_d = 1'b0;
  end

  always_comb begin
    entry_d          = entry_q;
    entry_d.pc       = id_pc;
    entry_d.inst     = id_inst;
    entry_d.rs1      = id_rs1;
    entry_d.rs2      = id_rs2;
    entry_d.rs1_used = id_rs1_used;
    entry_d.rs2_used = id_rs2_used;
    entry_d.rd       = id_rd;
    entry_d.rs1_data = id_rs1_data;
    entry_d.rs2_data = id_rs2_data;
    entry_d.imm      = id_imm;
    entry_d.ctrl     = id_ctrl;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) valid_q <= 1'b0;
    else       valid_q <= valid_d;
  end

  // NOTE: the data register is reset too, so ex_ctrl reads as a NOP and all outputs are zero after reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      entry_q      <= '0;
      entry_q.ctrl <= CTRL_W'(CTRL_NOP);
    end else if (in_fire) begin
      entry_q <= entry_d;
    end
  end

  assign ex_valid          = valid_q;
  assign ID_EX_RegisterRs1 = (valid_q && entry_q.rs1_used) ? entry_q.rs1 : '0;
  assign ID_EX_RegisterRs2 = (valid_q && entry_q.rs2_used) ? entry_q.rs2 : '0;
  assign ex_rd             = entry_q.rd;
  assign ex_pc             = entry_q.pc;
  assign ex_inst           = entry_q.inst;
  assign ex_rs1_data       = entry_q.rs1_data;
  assign ex_rs2_data       = entry_q.rs2_data;
  assign ex_imm            = entry_q.imm;
  assign ex_ctrl           = entry_q.ctrl;

`ifdef YSYX_22040759_HAZARD_STAT_EN
  logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q,  flush_cnt_d;

  // Both counters saturate at all-ones instead of wrapping.
  always_comb begin
    bubble_cnt_d = bubble_cnt_q;
    flush_cnt_d  = flush_cnt_q;
    if (id_valid && load_use && out_fire && !(&bubble_cnt_q)) bubble_cnt_d = bubble_cnt_q + 1'b1;
    if (ex_flush && valid_q && !(&flush_cnt_q))               flush_cnt_d  = flush_cnt_q + 1'b1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bubble_cnt_q <= '0;
      flush_cnt_q  <= '0;
    end else begin
      bubble_cnt_q <= bubble_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
    end
  end

  assign stat_bubble_cnt = bubble_cnt_q;
  assign stat_flush_cnt  = flush_cnt_q;
`else
  assign stat_bubble_cnt = '0;
  assign stat_flush_cnt  = '0;
`endif

endmodule

// File: tb/tb_ysyx_22040759_id_ex_stage.sv
// Directed bench for the ID/EX stage: handshake, load-use bubble, x0 load, flush, EX stall, async reset.
module tb_ysyx_22040759_id_ex_stage;

`ifdef YSYX_22040759_HAZARD_STAT_EN
  localparam bit STAT_EN = 1'b1;
`else
  localparam bit STAT_EN = 1'b0;
`endif

  localparam logic [15:0] C_ALU = 16'h0001;  // REGWRITE
  localparam logic [15:0] C_LD  = 16'h0009;  // REGWRITE | MEMREAD

  logic        clock, reset;
  logic        id_valid, id_ready;
  logic [63:0] id_pc;
  logic [31:0] id_inst;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic        id_rs1_used, id_rs2_used;
  logic [63:0] id_rs1_data, id_rs2_data, id_imm;
  logic [15:0] id_ctrl;
  logic        ex_ready, ex_flush, ex_valid;
  logic [4:0]  ID_EX_RegisterRs1, ID_EX_RegisterRs2, ex_rd;
  logic [63:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
  logic [31:0] ex_inst;
  logic [15:0] ex_ctrl;
  logic [31:0] stat_bubble_cnt, stat_flush_cnt;

  int vectors = 0;
  int miscompares = 0;

  ysyx_22040759_id_ex_stage dut (
    .clock(clock), .reset(reset),
    .id_valid(id_valid), .id_ready(id_ready),
    .id_pc(id_pc), .id_inst(id_inst),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .id_rd(id_rd), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
    .id_imm(id_imm), .id_ctrl(id_ctrl),
    .ex_ready(ex_ready), .ex_flush(ex_flush), .ex_valid(ex_valid),
    .ID_EX_RegisterRs1(ID_EX_RegisterRs1), .ID_EX_RegisterRs2(ID_EX_RegisterRs2),
    .ex_rd(ex_rd), .ex_pc(ex_pc), .ex_inst(ex_inst),
    .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data),
    .ex_imm(ex_imm), .ex_ctrl(ex_ctrl),
    .stat_bubble_cnt(stat_bubble_cnt), .stat_flush_cnt(stat_flush_cnt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Present one decode instruction; rs*_data and imm derive from pc so every entry is distinct.
  task automatic present(input logic v, input logic [63:0] pc, input logic [4:0] rs1, input logic u1,
                         input logic [4:0] rs2, input logic u2, input logic [4:0] rd, input logic [15:0] ctrl);
    id_valid    = v;
    id_pc       = pc;
    id_inst     = 32'h1300_0000 | 32'(pc[15:0]);
    id_rs1      = rs1;
    id_rs1_used = u1;
    id_rs2      = rs2;
    id_rs2_used = u2;
    id_rd       = rd;
    id_rs1_data = pc + 64'h1000;
    id_rs2_data = pc + 64'h2000;
    id_imm      = pc + 64'h3000;
    id_ctrl     = ctrl;
  endtask

  initial begin
    reset    = 1'b1;
    ex_ready = 1'b1;
    ex_flush = 1'b0;
    present(1'b0, 64'h0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 16'h0);
    #2;
    check("rst_ex_valid", 64'(ex_valid), 64'd0);
    check("rst_ex_ctrl",  64'(ex_ctrl),  64'd0);
    check("rst_ex_pc",    ex_pc,         64'd0);
    check("rst_rs1",      64'(ID_EX_RegisterRs1), 64'd0);
    check("rst_bubble",   64'(stat_bubble_cnt), 64'd0);
    check("rst_flush",    64'(stat_flush_cnt),  64'd0);
    #10 reset = 1'b0;
    tick();

    // 1: back-to-back ALU ops
    present(1'b1, 64'h100, 5'd1, 1'b1, 5'd2, 1'b1, 5'd3, C_ALU);
    #1 check("t1_ready0", 64'(id_ready), 64'd1);
    tick();
    check("t1_valid0", 64'(ex_valid), 64'd1);
    check("t1_pc0",    ex_pc, 64'h100);
    check("t1_rs1_0",  64'(ID_EX_RegisterRs1), 64'd1);
    check("t1_rs2_0",  64'(ID_EX_RegisterRs2), 64'd2);
    check("t1_rd0",    64'(ex_rd), 64'd3);
    present(1'b1, 64'h104, 5'd3, 1'b1, 5'd7, 1'b0, 5'd4, C_ALU);
    #1 check("t1_ready1", 64'(id_ready), 64'd1);
    tick();
    check("t1_valid1",  64'(ex_valid), 64'd1);
    check("t1_pc1",     ex_pc, 64'h104);
    check("t1_rs2_mask", 64'(ID_EX_RegisterRs2), 64'd0);
    check("t1_rs1data", ex_rs1_data, 64'h1104);
    check("t1_imm",     ex_imm, 64'h3104);
    check("t1_inst",    64'(ex_inst), 64'h1300_0104);

    // 2: ld x5 followed by add x6,x5,x1
    present(1'b1, 64'h108, 5'd2, 1'b1, 5'd0, 1'b0, 5'd5, C_LD);
    #1 check("t2_ready_ld", 64'(id_ready), 64'd1);
    tick();
    check("t2_ctrl_ld", 64'(ex_ctrl), 64'(C_LD));
    present(1'b1, 64'h10c, 5'd5, 1'b1, 5'd1, 1'b1, 5'd6, C_ALU);
    #1 check("t2_ready_hz", 64'(id_ready), 64'd0);
    tick();
    check("t2_bubble_valid", 64'(ex_valid), 64'd0);
    check("t2_bubble_pc",    ex_pc, 64'h108);
    check("t2_bubble_cnt",   64'(stat_bubble_cnt), STAT_EN ? 64'd1 : 64'd0);
    #1 check("t2_ready_after", 64'(id_ready), 64'd1);
    tick();
    check("t2_add_valid", 64'(ex_valid), 64'd1);
    check("t2_add_pc",    ex_pc, 64'h10c);
    check("t2_add_rs1",   64'(ID_EX_RegisterRs1), 64'd5);

    // 3: ld x0 then add x6,x0,x0 never stalls
    present(1'b1, 64'h110, 5'd2, 1'b1, 5'd0, 1'b0, 5'd0, C_LD);
    tick();
    present(1'b1, 64'h114, 5'd0, 1'b1, 5'd0, 1'b1, 5'd6, C_ALU);
    #1 check("t3_ready_x0", 64'(id_ready), 64'd1);
    tick();
    check("t3_valid", 64'(ex_valid), 64'd1);
    check("t3_pc",    ex_pc, 64'h114);
    check("t3_bubble_cnt", 64'(stat_bubble_cnt), STAT_EN ? 64'd1 : 64'd0);

    // 4: flush with a valid entry and a valid decode instruction
    present(1'b1, 64'h118, 5'd1, 1'b1, 5'd2, 1'b1, 5'd7, C_ALU);
    ex_flush = 1'b1;
    #1 check("t4_ready", 64'(id_ready), 64'd0);
    tick();
    ex_flush = 1'b0;
    check("t4_valid",  64'(ex_valid), 64'd0);
    check("t4_pc_held", ex_pc, 64'h114);
    check("t4_rs1_mask", 64'(ID_EX_RegisterRs1), 64'd0);
    check("t4_flush_cnt", 64'(stat_flush_cnt), STAT_EN ? 64'd1 : 64'd0);

    // 5: EX stalls for 3 cycles with a valid entry
    present(1'b1, 64'h11c, 5'd8, 1'b1, 5'd0, 1'b0, 5'd9, C_ALU);
    tick();
    check("t5_load", ex_pc, 64'h11c);
    ex_ready = 1'b0;
    present(1'b1, 64'h120, 5'd9, 1'b1, 5'd0, 1'b0, 5'd10, C_LD);
    for (int i = 0; i < 3; i++) begin
      #1 check("t5_stall_ready", 64'(id_ready), 64'd0);
      tick();
      check("t5_stall_valid", 64'(ex_valid), 64'd1);
      check("t5_stall_pc",    ex_pc, 64'h11c);
    end
    ex_ready = 1'b1;
    #1 check("t5_release_ready", 64'(id_ready), 64'd1);
    tick();
    check("t5_advance_pc", ex_pc, 64'h120);
    check("t5_advance_ctrl", 64'(ex_ctrl), 64'(C_LD));

    // 6: load-use while EX stalls, then asynchronous reset mid-stall
    ex_ready = 1'b0;
    present(1'b1, 64'h124, 5'd10, 1'b1, 5'd0, 1'b0, 5'd11, C_ALU);
    #1 check("t6_hz_ready", 64'(id_ready), 64'd0);
    tick();
    check("t6_hold_pc", ex_pc, 64'h120);
    check("t6_hold_rs1", 64'(ID_EX_RegisterRs1), 64'd9);
    #3 reset = 1'b1;
    #1;
    check("t6_rst_valid", 64'(ex_valid), 64'd0);
    check("t6_rst_rs1",   64'(ID_EX_RegisterRs1), 64'd0);
    check("t6_rst_rs2",   64'(ID_EX_RegisterRs2), 64'd0);
    check("t6_rst_pc",    ex_pc, 64'd0);
    #2 reset = 1'b0;
    ex_ready = 1'b1;
    present(1'b1, 64'h200, 5'd3, 1'b1, 5'd4, 1'b1, 5'd12, C_ALU);
    #1 check("t6_post_ready", 64'(id_ready), 64'd1);
    tick();
    check("t6_post_valid", 64'(ex_valid), 64'd1);
    check("t6_post_pc",    ex_pc, 64'h200);
    check("t6_post_rs2",   64'(ID_EX_RegisterRs2), 64'd4);
    check("t6_post_cnt",   64'(stat_bubble_cnt), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
